// File: rtl/pipelined_alu.sv
// Two-stage valid/ready ALU: S1 registers the request, S2 computes and registers
// result plus carry/overflow/zero flags. One op per cycle when not stalled.
module pipelined_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             negate,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_SLT  = 3'd6;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
    logic             negate;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             overflow;
    logic             zero;
  } rsp_t;

  req_t s1_q;
  rsp_t s2_q, s2_d;
  logic s1_valid, s2_valid, s2_adv, in_xfer;

  assign s2_adv   = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~s1_valid | s2_adv;
  assign in_xfer  = in_valid & in_ready;

  // Single shared adder: SLT always subtracts, ADD subtracts when negate is set.
  logic             inv, cout, ovf;
  logic [WIDTH-1:0] bx, sum;

  assign inv = (s1_q.sel == OP_SLT) | ((s1_q.sel == OP_ADD) & s1_q.negate);
  assign bx  = s1_q.b ^ {WIDTH{inv}};
  assign {cout, sum} = {1'b0, s1_q.a} + {1'b0, bx} + {{WIDTH{1'b0}}, inv};
  assign ovf = (s1_q.a[WIDTH-1] == bx[WIDTH-1]) & (sum[WIDTH-1] != s1_q.a[WIDTH-1]);

  always_comb begin
    s2_d = '0;
    case (s1_q.sel)
      OP_AND:  s2_d.result = s1_q.a & s1_q.b;
      OP_NOR:  s2_d.result = ~(s1_q.a | s1_q.b);
      OP_OR:   s2_d.result = s1_q.a | s1_q.b;
      OP_XOR:  s2_d.result = s1_q.a ^ s1_q.b;
      OP_NAND: s2_d.result = ~(s1_q.a & s1_q.b);
      OP_ADD: begin
        s2_d.result   = sum;
        s2_d.carryout = cout;
        s2_d.overflow = ovf;
      end
      OP_SLT: begin
        s2_d.result   = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
        s2_d.carryout = cout;
        s2_d.overflow = ovf;
      end
      default: s2_d.result = '0;
    endcase
    s2_d.zero = (s2_d.result == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= '0;
      s1_valid <= 1'b0;
    end else if (in_xfer) begin
      s1_q     <= '{a: a, b: b, sel: sel, negate: negate};
      s1_valid <= 1'b1;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 holds its flags after draining; only out_valid drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_q      <= '0;
      s2_q.zero <= 1'b1;
      s2_valid  <= 1'b0;
    end else if (s2_adv) begin
      s2_q     <= s2_d;
      s2_valid <= 1'b1;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;
  assign result    = s2_q.result;
  assign carryout  = s2_q.carryout;
  assign overflow  = s2_q.overflow;
  assign zero      = s2_q.zero;
endmodule
